shadow_reg_update_seq: RTL and testbench
========================================

Name: shadow_reg_update_seq

Overview:
Sequencer and arbiter that shares one shadowed register slice between NumReq requesters. For each granted request it performs the mandatory double-write (phase 0 stage, phase 1 commit) with identical data. It checks the update error flag and retries on mismatch. It also cleans up a dangling phase with a read-clear pulse and latches storage errors as fatal. It sits between the CSR/HW requesters and the shadowed subreg's we/wd/re/phase/err pins.

Parameters:
NumReq, 4, number of requesters (>=1)
DW, 32, register data width
GapCycles, 1, idle cycles between first and second write (0..15)
MaxRetry, 1, retries after an update error before reporting failure (0..3)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
req_i  input  NumReq  per-requester update request, level, held until gnt
req_data_i  input  NumReq*DW  per-requester data, slot i at [i*DW +: DW]
gnt_o  output  NumReq  one-hot, one-cycle grant; data latched on this cycle
done_o  output  1  one-cycle pulse: sequence finished
done_err_o  output  1  qualifies done_o: update failed after all retries
done_id_o  output  $clog2(NumReq) (min 1)  requester index for done_o
busy_o  output  1  high in every state except IDLE
sh_we_o  output  1  write strobe to the shadowed slice
sh_wd_o  output  DW  write data to the slice
sh_re_o  output  1  read pulse, clears the slice's phase
sh_phase_i  input  1  slice phase output
sh_err_update_i  input  1  slice update error (combinational vs. wd)
sh_err_storage_i  input  1  slice storage error
fatal_o  output  1  sticky storage-error indication

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state IDLE; all outputs 0; sh_wd_o 0.
  - round-robin pointer 0; retry counter 0.
  - Applies mid-sequence too. Any half-done phase is cleaned up by the next sequence's phase check.
- States: IDLE, PRECLR, WR1, GAP, WR2, CHECK, CLR, DONE, FATAL.
- IDLE, arbitration:
  - Round-robin starting at ptr. The winner w gets gnt_o[w]=1 for that cycle.
  - Data and index are latched; ptr <= w+1 (wraps to 0 at NumReq).
  - Next state: PRECLR if sh_phase_i=1, else WR1. No request: stay in IDLE.
- PRECLR: sh_re_o=1 for one cycle -> WR1.
- WR1: sh_we_o=1, sh_wd_o=latched data -> GAP if GapCycles>0, else WR2.
- GAP: counts GapCycles cycles with sh_we_o=0 -> WR2.
- WR2: sh_we_o=1 with the same data. sh_err_update_i is sampled this cycle into upd_err -> CHECK.
- CHECK:
  - upd_err=0 -> DONE (ok).
  - upd_err=1 and retry<MaxRetry: retry++ -> CLR, then WR1.
  - upd_err=1 and retry==MaxRetry -> CLR, then DONE (err).
  - Phase after a failed second write is 0 already. CLR is still issued for robustness.
- CLR: sh_re_o=1 for one cycle.
- DONE: done_o=1, done_err_o=final error, done_id_o=latched index. Retry counter cleared -> IDLE.
- Minimum latency from grant to done_o (no pre-clear, no error): 3+GapCycles cycles after the grant cycle.
- FATAL:
  - Entered from any state on the cycle after sh_err_storage_i=1 (highest priority).
  - fatal_o=1; sh_we_o, sh_re_o and gnt_o forced 0.
  - An in-flight sequence is abandoned with no done_o. Exit only via rst_i.
- Outputs sh_we_o, sh_re_o, gnt_o, done_o are registered-state decodes. sh_we_o and sh_re_o are never high together.
- Requests that arrive while busy_o=1 wait. Dropping req_i before its grant is legal and simply loses arbitration.

Decomposition:
- Package shadow_seq_pkg: state enum (one-hot encoded), width constants for the gap and retry counters.
- One sub-module: rr_arbiter (NumReq inputs, pointer, one-hot grant, index out), reusable elsewhere.

Test Plan:
- Single update: req_i=4'b0010, data 0xA5A5_0001, phase 0, no errors.
  - gnt_o[1] pulses; sh_we_o high in WR1 and WR2 with 0xA5A5_0001.
  - done_o at grant+4 (GapCycles=1); done_err_o=0; done_id_o=1.
- Round-robin: all four requests held.
  - Grants go 0,1,2,3,0 across consecutive sequences; no grant while busy_o=1.
- Update error with retry (MaxRetry=1): sh_err_update_i=1 during the first WR2 only.
  - Sequence shows sh_re_o pulse, then WR1/WR2 repeat.
  - done_o with done_err_o=0.
- Persistent update error: sh_err_update_i=1 in both WR2 cycles.
  - Two full attempts and two CLR pulses, then done_err_o=1.
- Dangling phase: sh_phase_i=1 at grant.
  - sh_re_o pulses one cycle before the first sh_we_o.
- Storage error and reset: sh_err_storage_i=1 during GAP.
  - Next cycle fatal_o=1; no sh_we_o and no done_o afterwards.
  - rst_i=1 for one cycle clears fatal_o; a new request is granted normally.

Source files
------------

// File: rtl/shadow_seq_pkg.sv
// Shared types and constants for the shadowed-register update sequencer.
package shadow_seq_pkg;

  // One-hot so each output is a single state-bit decode.
  typedef enum logic [8:0] {
    ST_IDLE   = 9'h001,
    ST_PRECLR = 9'h002,
    ST_WR1    = 9'h004,
    ST_GAP    = 9'h008,
    ST_WR2    = 9'h010,
    ST_CHECK  = 9'h020,
    ST_CLR    = 9'h040,
    ST_DONE   = 9'h080,
    ST_FATAL  = 9'h100
  } seq_state_e;

  localparam int unsigned GAP_CW   = 4;
  localparam int unsigned RETRY_CW = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest offset from ptr_i wins; one-hot grant plus index.
module rr_arbiter
  import shadow_seq_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IW     = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);

  logic [IW:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NumReq)) cand = cand - (IW+1)'(NumReq);
      if (req_i[cand[IW-1:0]]) begin
        idx_o   = cand[IW-1:0];
        valid_o = 1'b1;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/shadow_reg_update_seq.sv
// Arbitrates requesters onto one shadowed register slice and runs the
// stage/commit double-write with update-error retry and storage-error lockout.
module shadow_reg_update_seq
  import shadow_seq_pkg::*;
#(
  parameter  int unsigned NumReq    = 4,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned GapCycles = 1,
  parameter  int unsigned MaxRetry  = 1,
  localparam int unsigned IW        = idx_w(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*DW-1:0] req_data_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic                 done_o,
  output logic                 done_err_o,
  output logic [IW-1:0]        done_id_o,
  output logic                 busy_o,
  output logic                 sh_we_o,
  output logic [DW-1:0]        sh_wd_o,
  output logic                 sh_re_o,
  input  logic                 sh_phase_i,
  input  logic                 sh_err_update_i,
  input  logic                 sh_err_storage_i,
  output logic                 fatal_o
);

  localparam logic [GAP_CW-1:0]   GapLoad  = GAP_CW'(GapCycles > 0 ? GapCycles - 1 : 0);
  localparam logic [RETRY_CW-1:0] RetryMax = RETRY_CW'(MaxRetry);

  seq_state_e            state_q, state_d;
  logic [NumReq-1:0]     arb_gnt, gnt_q;
  logic [IW-1:0]         arb_idx, ptr_q, id_q;
  logic                  arb_valid;
  logic [DW-1:0]         data_q;
  logic [GAP_CW-1:0]     gap_q;
  logic [RETRY_CW-1:0]   retry_q;
  logic                  upd_err_q, err_q;
  logic                  take;

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_valid) state_d = sh_phase_i ? ST_PRECLR : ST_WR1;
      ST_PRECLR: state_d = ST_WR1;
      ST_WR1:    state_d = (GapCycles > 0) ? ST_GAP : ST_WR2;
      ST_GAP:    if (gap_q == '0) state_d = ST_WR2;
      ST_WR2:    state_d = ST_CHECK;
      ST_CHECK:  state_d = upd_err_q ? ST_CLR : ST_DONE;
      ST_CLR:    state_d = err_q ? ST_DONE : ST_WR1;
      ST_DONE:   state_d = ST_IDLE;
      ST_FATAL:  state_d = ST_FATAL;
      default:   state_d = ST_IDLE;
    endcase
    if (sh_err_storage_i) state_d = ST_FATAL;
  end

  // A grant lost to a same-cycle storage error is never shown to the requester.
  assign take = (state_q == ST_IDLE) && arb_valid && !sh_err_storage_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q     <= '0;
      data_q    <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
      retry_q   <= '0;
      upd_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      gnt_q <= '0;
      if (take) begin
        gnt_q   <= arb_gnt;
        data_q  <= req_data_i[32'(arb_idx)*DW +: DW];
        id_q    <= arb_idx;
        ptr_q   <= (arb_idx == IW'(NumReq - 1)) ? '0 : arb_idx + IW'(1);
        retry_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == ST_WR1) gap_q <= GapLoad;
      if (state_q == ST_GAP && gap_q != '0) gap_q <= gap_q - GAP_CW'(1);
      if (state_q == ST_WR2) upd_err_q <= sh_err_update_i;
      if (state_q == ST_CHECK && upd_err_q) begin
        if (retry_q < RetryMax) retry_q <= retry_q + RETRY_CW'(1);
        else                    err_q   <= 1'b1;
      end
      if (state_q == ST_DONE) retry_q <= '0;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign sh_we_o    = (state_q == ST_WR1) || (state_q == ST_WR2);
  assign sh_re_o    = (state_q == ST_PRECLR) || (state_q == ST_CLR);
  assign sh_wd_o    = data_q;
  assign done_o     = (state_q == ST_DONE);
  assign done_err_o = (state_q == ST_DONE) && err_q;
  assign done_id_o  = (state_q == ST_DONE) ? id_q : '0;
  assign fatal_o    = (state_q == ST_FATAL);
  assign gnt_o      = (state_q == ST_FATAL) ? '0 : gnt_q;

endmodule

// File: tb/tb_shadow_reg_update_seq.sv
// Self-checking bench: per-scenario tasks, expected completions queued at request time.
module tb_shadow_reg_update_seq;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    gnt_o;
  logic            done_o, done_err_o, busy_o, sh_we_o, sh_re_o, fatal_o;
  logic [1:0]      done_id_o;
  logic [DW-1:0]   sh_wd_o;
  logic            sh_phase_i, sh_err_update_i, sh_err_storage_i;

  shadow_reg_update_seq #(.NumReq(N), .DW(DW), .GapCycles(1), .MaxRetry(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o), .done_o(done_o), .done_err_o(done_err_o), .done_id_o(done_id_o),
    .busy_o(busy_o), .sh_we_o(sh_we_o), .sh_wd_o(sh_wd_o), .sh_re_o(sh_re_o),
    .sh_phase_i(sh_phase_i), .sh_err_update_i(sh_err_update_i),
    .sh_err_storage_i(sh_err_storage_i), .fatal_o(fatal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int id; bit err; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int err_mode, wr_cnt;
  bit drop_on_gnt, prev_busy;
  logic [DW-1:0] exp_wd;
  int t_gnt, t_done, t_we1, t_re1, we_cnt, re_cnt, wd_bad, overlap, gnt_busy, done_id;
  bit done_err, timeout;
  logic [N-1:0] gnt_val;

  task automatic tick();
    @(negedge clk_i);
    cyc++;
    prev_busy = busy_o;
  endtask

  task automatic do_reset();
    req_i = '0; sh_phase_i = 0; sh_err_update_i = 0; sh_err_storage_i = 0;
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
  endtask

  // Runs the DUT until done_o, acting as the slice and recording the trace.
  task automatic run_seq(input int budget);
    t_gnt = -1; t_done = -1; t_we1 = -1; t_re1 = -1;
    we_cnt = 0; re_cnt = 0; wd_bad = 0; overlap = 0; gnt_busy = 0; wr_cnt = 0;
    timeout = 1; gnt_val = '0; exp_wd = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      cyc++;
      if (gnt_o != '0) begin
        if (prev_busy || t_gnt >= 0) gnt_busy++;
        if (t_gnt < 0) begin t_gnt = cyc; gnt_val = gnt_o; end
        for (int b = 0; b < N; b++) if (gnt_o[b]) exp_wd = req_data_i[b*DW +: DW];
        if (drop_on_gnt) req_i = req_i & ~gnt_o;
      end
      if (sh_we_o) begin
        we_cnt++; wr_cnt++;
        if (t_we1 < 0) t_we1 = cyc;
        if (sh_wd_o !== exp_wd) wd_bad++;
        sh_err_update_i = (wr_cnt % 2 == 0) && (err_mode == 2 || (err_mode == 1 && wr_cnt == 2));
      end else sh_err_update_i = 0;
      if (sh_re_o) begin
        re_cnt++;
        if (t_re1 < 0) t_re1 = cyc;
        sh_phase_i = 0;
      end
      if (sh_we_o && sh_re_o) overlap++;
      prev_busy = busy_o;
      if (done_o) begin
        t_done = cyc; done_id = int'(done_id_o); done_err = done_err_o; timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({gnt_o, done_o, done_err_o, done_id_o, busy_o, sh_we_o, sh_re_o, sh_wd_o, fatal_o} !== '0)
      $display("FAIL reset_outputs got gnt=%b done=%b busy=%b we=%b re=%b wd=%h fatal=%b want all 0",
               gnt_o, done_o, busy_o, sh_we_o, sh_re_o, sh_wd_o, fatal_o);
    else n_pass++;
    tick();
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_single();
    err_mode = 0; drop_on_gnt = 1;
    sb.push_back('{1, 1'b0});
    req_i = 4'b0010;
    run_seq(20);
    n_checks++; if (timeout !== 0) $display("FAIL single_timeout got %0d want 0", timeout); else n_pass++;
    n_checks++; if (gnt_val !== 4'b0010) $display("FAIL single_gnt got %b want 0010", gnt_val); else n_pass++;
    n_checks++; if (we_cnt !== 2) $display("FAIL single_we_cnt got %0d want 2", we_cnt); else n_pass++;
    n_checks++; if (exp_wd !== 32'hA5A5_0001 || wd_bad !== 0)
      $display("FAIL single_wd got bad=%0d data=%h want 0 bad data a5a50001", wd_bad, exp_wd); else n_pass++;
    n_checks++; if (t_we1 !== t_gnt) $display("FAIL single_wr1 got %0d want %0d", t_we1, t_gnt); else n_pass++;
    n_checks++; if (t_done - t_gnt !== 4) $display("FAIL single_latency got %0d want 4", t_done - t_gnt); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (done_id !== e.id) $display("FAIL single_id got %0d want %0d", done_id, e.id); else n_pass++;
    n_checks++; if (done_err !== e.err) $display("FAIL single_err got %0d want %0d", done_err, e.err); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    err_mode = 0; drop_on_gnt = 0;
    sb.push_back('{0, 1'b0}); sb.push_back('{1, 1'b0}); sb.push_back('{2, 1'b0});
    sb.push_back('{3, 1'b0}); sb.push_back('{0, 1'b0});
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_seq(20);
      e = sb.pop_front();
      n_checks++; if (timeout !== 0 || gnt_val !== N'(1 << e.id))
        $display("FAIL rr_gnt%0d got %b timeout=%0d want %b", k, gnt_val, timeout, N'(1 << e.id)); else n_pass++;
      n_checks++; if (done_id !== e.id) $display("FAIL rr_id%0d got %0d want %0d", k, done_id, e.id); else n_pass++;
      n_checks++; if (gnt_busy !== 0 || overlap !== 0)
        $display("FAIL rr_busy%0d got extra_gnt=%0d overlap=%0d want 0", k, gnt_busy, overlap); else n_pass++;
      n_checks++; if (t_done - t_gnt !== 4 || wd_bad !== 0)
        $display("FAIL rr_seq%0d got lat=%0d bad=%0d want 4/0", k, t_done - t_gnt, wd_bad); else n_pass++;
    end
    req_i = '0;
    tick(); tick();
  endtask

  task automatic test_retry();
    err_mode = 1; drop_on_gnt = 1;
    sb.push_back('{2, 1'b0});
    req_i = 4'b0100;
    run_seq(30);
    e = sb.pop_front();
    n_checks++; if (timeout !== 0) $display("FAIL retry_timeout got %0d want 0", timeout); else n_pass++;
    n_checks++; if (we_cnt !== 4 || re_cnt !== 1)
      $display("FAIL retry_counts got we=%0d re=%0d want 4/1", we_cnt, re_cnt); else n_pass++;
    n_checks++; if (t_re1 - t_gnt !== 4) $display("FAIL retry_clr got %0d want 4", t_re1 - t_gnt); else n_pass++;
    n_checks++; if (t_done - t_gnt !== 9) $display("FAIL retry_latency got %0d want 9", t_done - t_gnt); else n_pass++;
    n_checks++; if (done_id !== e.id || done_err !== e.err)
      $display("FAIL retry_done got id=%0d err=%0d want %0d/%0d", done_id, done_err, e.id, e.err); else n_pass++;
    n_checks++; if (overlap !== 0 || wd_bad !== 0)
      $display("FAIL retry_strobes got overlap=%0d bad=%0d want 0/0", overlap, wd_bad); else n_pass++;
  endtask

  task automatic test_persistent();
    err_mode = 2; drop_on_gnt = 1;
    sb.push_back('{3, 1'b1});
    req_i = 4'b1000;
    run_seq(30);
    e = sb.pop_front();
    n_checks++; if (timeout !== 0) $display("FAIL persist_timeout got %0d want 0", timeout); else n_pass++;
    n_checks++; if (we_cnt !== 4 || re_cnt !== 2)
      $display("FAIL persist_counts got we=%0d re=%0d want 4/2", we_cnt, re_cnt); else n_pass++;
    n_checks++; if (t_done - t_gnt !== 10) $display("FAIL persist_latency got %0d want 10", t_done - t_gnt); else n_pass++;
    n_checks++; if (done_err !== e.err) $display("FAIL persist_err got %0d want %0d", done_err, e.err); else n_pass++;
    n_checks++; if (done_id !== e.id) $display("FAIL persist_id got %0d want %0d", done_id, e.id); else n_pass++;
    err_mode = 0;
  endtask

  task automatic test_dangling();
    err_mode = 0; drop_on_gnt = 1;
    sh_phase_i = 1;
    sb.push_back('{0, 1'b0});
    req_i = 4'b0001;
    run_seq(20);
    e = sb.pop_front();
    n_checks++; if (timeout !== 0) $display("FAIL dangle_timeout got %0d want 0", timeout); else n_pass++;
    n_checks++; if (re_cnt !== 1 || t_re1 !== t_gnt)
      $display("FAIL dangle_preclr got re=%0d at %0d want 1 at %0d", re_cnt, t_re1, t_gnt); else n_pass++;
    n_checks++; if (t_we1 - t_re1 !== 1) $display("FAIL dangle_order got %0d want 1", t_we1 - t_re1); else n_pass++;
    n_checks++; if (t_done - t_gnt !== 5) $display("FAIL dangle_latency got %0d want 5", t_done - t_gnt); else n_pass++;
    n_checks++; if (done_id !== e.id || done_err !== e.err)
      $display("FAIL dangle_done got id=%0d err=%0d want %0d/%0d", done_id, done_err, e.id, e.err); else n_pass++;
  endtask

  task automatic test_fatal();
    bit seen_we;
    int bad;
    err_mode = 0; drop_on_gnt = 1;
    sb.push_back('{1, 1'b0});
    req_i = 4'b0010;
    seen_we = 0;
    for (int i = 0; i < 10 && !seen_we; i++) begin
      tick();
      if (gnt_o != '0) req_i = req_i & ~gnt_o;
      if (sh_we_o) seen_we = 1;
    end
    n_checks++; if (seen_we !== 1'b1) $display("FAIL fatal_wr1 got %0d want 1", seen_we); else n_pass++;
    tick();
    sh_err_storage_i = 1;
    tick();
    sh_err_storage_i = 0;
    n_checks++; if (fatal_o !== 1'b1) $display("FAIL fatal_set got %b want 1", fatal_o); else n_pass++;
    bad = 0;
    req_i = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      if (sh_we_o || sh_re_o || done_o || gnt_o != '0 || !fatal_o) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL fatal_lock got %0d bad cycles want 0", bad); else n_pass++;
    void'(sb.pop_front());
    req_i = '0;
    rst_i = 1;
    tick();
    n_checks++; if (fatal_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL fatal_reset got fatal=%b busy=%b want 0/0", fatal_o, busy_o); else n_pass++;
    rst_i = 0;
    sb.push_back('{2, 1'b0});
    req_i = 4'b0100;
    run_seq(20);
    e = sb.pop_front();
    n_checks++; if (timeout !== 0 || gnt_val !== 4'b0100)
      $display("FAIL fatal_regrant got %b timeout=%0d want 0100", gnt_val, timeout); else n_pass++;
    n_checks++; if (t_done - t_gnt !== 4 || done_id !== e.id || done_err !== e.err)
      $display("FAIL fatal_redone got lat=%0d id=%0d err=%0d want 4/%0d/%0d",
               t_done - t_gnt, done_id, done_err, e.id, e.err); else n_pass++;
  endtask

  initial begin
    req_i = '0; rst_i = 1; sh_phase_i = 0; sh_err_update_i = 0; sh_err_storage_i = 0;
    err_mode = 0; drop_on_gnt = 1; prev_busy = 0;
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = 32'hA5A5_0000 + DW'(i);
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_persistent();
    test_dangling();
    test_fatal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
